// File: rtl/fir_pkg.sv
// fir_pkg
//   Shared definitions for the time-multiplexed FIR blocks.
//   - state_t      : sequencer states (IDLE, MAC, OUT)
//   - DEF_*        : default filter geometry used as parameter defaults
//   - ACC_W, PTR_W : accumulator and pointer widths for the default geometry
//   - acc_width / ptr_width : the same widths for any geometry, usable in
//     localparam expressions of parameterised modules
//   - saturate     : clamps a wide signed value into an out_w-bit signed range;
//     shared with other filter blocks, so it works on a fixed wide container
//     and takes the target width as an argument.
// No ports (package).
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int DEF_NTAPS  = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 8;
  localparam int DEF_OUT_W  = 16;

  // Widest value saturate() can handle.
  localparam int SAT_MAX_W = 64;

  // Pointer width; never below 1 so single-bit indexes stay legal.
  function automatic int ptr_width(input int ntaps);
    return (ntaps < 2) ? 1 : $clog2(ntaps);
  endfunction

  // Sum of ntaps products of data_w x coef_w signed values cannot exceed
  // this width, so the accumulator never overflows.
  function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + ptr_width(ntaps);
  endfunction

  localparam int PTR_W = ptr_width(DEF_NTAPS);
  localparam int ACC_W = acc_width(DEF_DATA_W, DEF_COEF_W, DEF_NTAPS);

  // Clamp value into [-2^(out_w-1), 2^(out_w-1)-1].
  function automatic logic signed [SAT_MAX_W-1:0] saturate(
    input logic signed [SAT_MAX_W-1:0] value,
    input int unsigned                 out_w
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// fir_sample_ring
//   NTAPS x DATA_W circular sample buffer for the FIR sequencer.
//   Owns the write pointer. A write stores a sample at the current write
//   pointer; the pointer only moves when 'advance' is pulsed, so the newest
//   sample stays at offset 0 for the whole MAC pass.
// Ports
//   clk      in   1        rising-edge clock
//   rst      in   1        synchronous active-high reset (ring and pointer to 0)
//   we       in   1        write wdata at ring[wr_ptr]
//   wdata    in   DATA_W   signed sample
//   advance  in   1        step wr_ptr by one, wrapping NTAPS-1 -> 0
//   offset   in   PTR_W    tap offset back from wr_ptr (0 = newest)
//   rdata    out  DATA_W   ring[(wr_ptr - offset) mod NTAPS]
module fir_sample_ring
  import fir_pkg::*;
#(
  parameter int NTAPS  = DEF_NTAPS,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic signed [DATA_W-1:0]       wdata,
  input  logic                           advance,
  input  logic [ptr_width(NTAPS)-1:0]    offset,
  output logic signed [DATA_W-1:0]       rdata
);

  localparam int PTR_BITS = ptr_width(NTAPS);
  localparam logic [PTR_BITS:0]   DEPTH    = (PTR_BITS + 1)'(NTAPS);
  localparam logic [PTR_BITS-1:0] LAST_IDX = PTR_BITS'(NTAPS - 1);

  logic signed [DATA_W-1:0] ring [NTAPS];
  logic [PTR_BITS-1:0]      wr_ptr;
  logic [PTR_BITS:0]        rd_sum;
  logic [PTR_BITS-1:0]      rd_idx;

  // Modular subtraction done one bit wider so it also works when NTAPS is
  // not a power of two: add the depth back whenever the offset reaches past
  // slot 0.
  always_comb begin
    rd_sum = {1'b0, wr_ptr} - {1'b0, offset};
    if (wr_ptr < offset) begin
      rd_sum = rd_sum + DEPTH;
    end
    rd_idx = rd_sum[PTR_BITS-1:0];
  end

  assign rdata = ring[rd_idx];

  // Storage and pointer. Reset clears the history so a restarted filter
  // does not see stale samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        ring[i] <= '0;
      end
    end else begin
      if (we) begin
        ring[wr_ptr] <= wdata;
      end
      if (advance) begin
        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//   Time-multiplexed FIR controller. One shared multiplier-accumulator walks
//   NTAPS taps per accepted sample, then presents y[n] on a valid/ready
//   output. Coefficients are writable at runtime while idle.
//
//   Build option: define FIR_SAT_EN to saturate the final accumulator into
//   the OUT_W signed range; otherwise m_data is the low OUT_W bits of the
//   accumulator (two's-complement wrap).
//
// Ports
//   clk       in   1        rising-edge clock
//   rst       in   1        synchronous active-high reset
//   s_valid   in   1        input sample valid
//   s_ready   out  1        sequencer can accept a sample (IDLE only)
//   s_data    in   DATA_W   signed sample x[n]
//   m_valid   out  1        y[n] valid (OUT state)
//   m_ready   in   1        consumer accepts y[n]
//   m_data    out  OUT_W    signed y[n], held until accepted
//   cfg_we    in   1        coefficient write strobe
//   cfg_addr  in   PTR_W    tap index
//   cfg_data  in   COEF_W   signed coefficient
//   cfg_err   out  1        one-cycle pulse: write rejected (busy or bad index)
//   busy      out  1        high in MAC or OUT
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS  = DEF_NTAPS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic signed [DATA_W-1:0]       s_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic signed [OUT_W-1:0]        m_data,
  input  logic                           cfg_we,
  input  logic [ptr_width(NTAPS)-1:0]    cfg_addr,
  input  logic signed [COEF_W-1:0]       cfg_data,
  output logic                           cfg_err,
  output logic                           busy
);

  localparam int PTR_BITS  = ptr_width(NTAPS);
  localparam int ACC_BITS  = acc_width(DATA_W, COEF_W, NTAPS);
  localparam int PROD_BITS = DATA_W + COEF_W;
  localparam logic [PTR_BITS-1:0] LAST_TAP = PTR_BITS'(NTAPS - 1);

  state_t                      state;
  logic signed [COEF_W-1:0]    coef [NTAPS];
  logic [PTR_BITS-1:0]         tap;
  logic                        draining;
  logic signed [ACC_BITS-1:0]  acc;
  logic signed [ACC_BITS-1:0]  acc_final;
  logic signed [PROD_BITS-1:0] prod;
  logic signed [PROD_BITS-1:0] mult;
  logic signed [DATA_W-1:0]    ring_rd;
  logic signed [OUT_W-1:0]     result;
  logic                        ring_we;
  logic                        ring_advance;
  logic                        addr_ok;

  // Sample is taken whenever IDLE sees s_valid (s_ready is always 1 there).
  // The write pointer moves on the final MAC cycle so every tap of this pass
  // is read relative to the slot that holds the newest sample.
  assign ring_we      = (state == IDLE) && s_valid;
  assign ring_advance = (state == MAC) && draining;

  fir_sample_ring #(
    .NTAPS  (NTAPS),
    .DATA_W (DATA_W)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .we      (ring_we),
    .wdata   (s_data),
    .advance (ring_advance),
    .offset  (tap),
    .rdata   (ring_rd)
  );

  // Indexes beyond NTAPS-1 exist only when NTAPS is not a power of two.
  assign addr_ok = (32'(cfg_addr) < 32'(NTAPS));

  // The multiplier output is registered (prod) before it is accumulated, so
  // each tap is added one cycle after it is read. The extra draining cycle
  // at the end folds in the last product and loads the output register.
  assign mult      = PROD_BITS'(coef[tap]) * PROD_BITS'(ring_rd);
  assign acc_final = acc + ACC_BITS'(prod);

`ifdef FIR_SAT_EN
  logic signed [SAT_MAX_W-1:0] sat_wide;
  assign sat_wide = saturate(SAT_MAX_W'(acc_final), OUT_W);
  assign result   = OUT_W'(sat_wide);
`else
  assign result = OUT_W'(acc_final);
`endif

  // Sequencer FSM with coefficient bank and registered handshake outputs.
  // A coefficient write in IDLE lands on the same edge a sample may be
  // accepted; the MAC pass starts reading coefficients one cycle later, so
  // the new value is already used for that sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s_ready  <= 1'b1;
      m_valid  <= 1'b0;
      m_data   <= '0;
      cfg_err  <= 1'b0;
      busy     <= 1'b0;
      tap      <= '0;
      draining <= 1'b0;
      acc      <= '0;
      prod     <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        coef[i] <= COEF_W'(1);
      end
    end else begin
      cfg_err <= 1'b0;
      if (cfg_we) begin
        if ((state == IDLE) && addr_ok) begin
          coef[cfg_addr] <= cfg_data;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (s_valid) begin
            state    <= MAC;
            s_ready  <= 1'b0;
            busy     <= 1'b1;
            tap      <= '0;
            draining <= 1'b0;
            acc      <= '0;
            prod     <= '0;
          end
        end

        MAC: begin
          if (!draining) begin
            acc  <= acc_final;
            prod <= mult;
            if (tap == LAST_TAP) begin
              draining <= 1'b1;
            end else begin
              tap <= tap + 1'b1;
            end
          end else begin
            m_data   <= result;
            m_valid  <= 1'b1;
            draining <= 1'b0;
            state    <= OUT;
          end
        end

        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer
//   Directed bench for fir_mac_sequencer with NTAPS=4 and default widths.
//   Each scenario task drives its own vectors and compares against
//   hand-computed results. Define FIR_SAT_EN for both DUT and bench to
//   exercise the saturating build.
module tb_fir_mac_sequencer;

  logic               clk;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic signed [7:0]  s_data;
  logic               m_valid;
  logic               m_ready;
  logic signed [15:0] m_data;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic signed [7:0]  cfg_data;
  logic               cfg_err;
  logic               busy;

  int n_compared;
  int n_mismatched;

  fir_mac_sequencer #(
    .NTAPS  (4),
    .DATA_W (8),
    .COEF_W (8),
    .OUT_W  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_err  (cfg_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit in case a handshake never completes.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_coef(input logic [1:0] addr, input logic signed [7:0] value);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = value;
    tick();
    cfg_we = 1'b0;
  endtask

  // Push one sample, wait for y, complete the output handshake.
  task automatic send_sample(input logic signed [7:0] x, output logic signed [15:0] y,
                             output int lat, output bit ok);
    int cycles;
    ok = 1'b0;
    y  = '0;
    cycles = 0;
    while (!s_ready && cycles < 50) begin
      tick();
      cycles++;
    end
    s_valid = 1'b1;
    s_data  = x;
    tick();
    s_valid = 1'b0;
    lat = 0;
    while (!m_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (m_valid) begin
      y  = m_data;
      ok = 1'b1;
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_compared++;
    if (s_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_s_ready: got %b expected 1", s_ready);
    end
    n_compared++;
    if (m_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid);
    end
    n_compared++;
    if (m_data !== 16'sd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_m_data: got %0d expected 0", m_data);
    end
    n_compared++;
    if ({cfg_err, busy} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_err_busy: got %b expected 00", {cfg_err, busy});
    end
  endtask

  task automatic test_impulse_default();
    logic signed [7:0]  xin [5] = '{8'sd10, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
    logic signed [15:0] yexp [5] = '{16'sd10, 16'sd10, 16'sd10, 16'sd10, 16'sd0};
    logic signed [15:0] y;
    int lat;
    bit ok;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      send_sample(xin[i], y, lat, ok);
      n_compared++;
      if (!ok || y !== yexp[i]) begin
        n_mismatched++;
        $display("[TB] FAIL impulse_default[%0d]: got %0d (valid=%b) expected %0d", i, y, ok, yexp[i]);
      end
      if (i == 0) begin
        n_compared++;
        if (lat !== 5) begin
          n_mismatched++;
          $display("[TB] FAIL latency: got %0d edges expected 5", lat);
        end
      end
    end
  endtask

  task automatic test_coef_impulse();
    logic signed [7:0]  xin [5] = '{8'sd10, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
    logic signed [15:0] yexp [5] = '{16'sd10, 16'sd20, 16'sd30, 16'sd40, 16'sd0};
    logic signed [15:0] y;
    int lat;
    bit ok;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set_coef(2'(i), 8'(i + 1));
    end
    n_compared++;
    if (cfg_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL cfg_idle_err: got %b expected 0", cfg_err);
    end
    for (int i = 0; i < 5; i++) begin
      send_sample(xin[i], y, lat, ok);
      n_compared++;
      if (!ok || y !== yexp[i]) begin
        n_mismatched++;
        $display("[TB] FAIL coef_impulse[%0d]: got %0d (valid=%b) expected %0d", i, y, ok, yexp[i]);
      end
    end
  endtask

  task automatic test_step_wrap();
    logic signed [15:0] yexp [6] = '{16'sd10, 16'sd20, 16'sd30, 16'sd40, 16'sd40, 16'sd40};
    logic signed [15:0] y;
    int lat;
    bit ok;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      send_sample(8'sd10, y, lat, ok);
      n_compared++;
      if (!ok || y !== yexp[i]) begin
        n_mismatched++;
        $display("[TB] FAIL step_wrap[%0d]: got %0d (valid=%b) expected %0d", i, y, ok, yexp[i]);
      end
    end
  endtask

  // y held under backpressure while a second sample waits on s_valid.
  task automatic test_backpressure();
    int cycles;
    int bad;
    logic signed [15:0] y;
    int lat;
    bit ok;
    apply_reset();
    s_valid = 1'b1;
    s_data  = 8'sd7;
    tick();
    s_data  = 8'sd99;
    cycles = 0;
    while (!m_valid && cycles < 50) begin
      tick();
      cycles++;
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (m_valid !== 1'b1 || m_data !== 16'sd7 || s_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
      end
      tick();
    end
    n_compared++;
    if (bad != 0) begin
      n_mismatched++;
      $display("[TB] FAIL backpressure_hold: got %0d bad cycles (last m_data=%0d) expected 0", bad, m_data);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_compared++;
    if ({m_valid, s_ready} !== 2'b01) begin
      n_mismatched++;
      $display("[TB] FAIL backpressure_release: got %b expected 01", {m_valid, s_ready});
    end
    // 99 has been waiting on s_valid; it is taken now and joins 7 in the ring.
    send_sample(8'sd99, y, lat, ok);
    n_compared++;
    if (!ok || y !== 16'sd106) begin
      n_mismatched++;
      $display("[TB] FAIL backpressure_next: got %0d (valid=%b) expected 106", y, ok);
    end
  endtask

  task automatic test_cfg_busy();
    int cycles;
    logic signed [15:0] y;
    int lat;
    bit ok;
    apply_reset();
    s_valid = 1'b1;
    s_data  = 8'sd10;
    tick();
    s_valid = 1'b0;
    set_coef(2'd0, 8'sd5);
    n_compared++;
    if (cfg_err !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL cfg_err_pulse: got %b expected 1", cfg_err);
    end
    tick();
    n_compared++;
    if (cfg_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL cfg_err_width: got %b expected 0", cfg_err);
    end
    cycles = 0;
    while (!m_valid && cycles < 50) begin
      tick();
      cycles++;
    end
    n_compared++;
    if (m_valid !== 1'b1 || m_data !== 16'sd10) begin
      n_mismatched++;
      $display("[TB] FAIL cfg_dropped: got %0d (valid=%b) expected 10", m_data, m_valid);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    // Next result still uses coef[0]=1: ring holds 10, new sample 1.
    send_sample(8'sd1, y, lat, ok);
    n_compared++;
    if (!ok || y !== 16'sd11) begin
      n_mismatched++;
      $display("[TB] FAIL cfg_unchanged: got %0d (valid=%b) expected 11", y, ok);
    end
  endtask

  // Coefficient write and sample on the same edge: new coefficient applies.
  task automatic test_cfg_with_sample();
    int cycles;
    apply_reset();
    cfg_we   = 1'b1;
    cfg_addr = 2'd0;
    cfg_data = 8'sd3;
    s_valid  = 1'b1;
    s_data   = 8'sd5;
    tick();
    cfg_we  = 1'b0;
    s_valid = 1'b0;
    n_compared++;
    if (cfg_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL cfg_with_sample_err: got %b expected 0", cfg_err);
    end
    cycles = 0;
    while (!m_valid && cycles < 50) begin
      tick();
      cycles++;
    end
    n_compared++;
    if (m_valid !== 1'b1 || m_data !== 16'sd15) begin
      n_mismatched++;
      $display("[TB] FAIL cfg_with_sample: got %0d (valid=%b) expected 15", m_data, m_valid);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mac();
    int bad;
    logic signed [15:0] y;
    int lat;
    bit ok;
    apply_reset();
    s_valid = 1'b1;
    s_data  = 8'sd20;
    tick();
    s_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_compared++;
    if ({s_ready, m_valid, busy, cfg_err} !== 4'b1000 || m_data !== 16'sd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_mid_mac: got rdy/vld/busy/err=%b m_data=%0d expected 1000 and 0",
               {s_ready, m_valid, busy, cfg_err}, m_data);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_valid !== 1'b0) begin
        bad++;
      end
      tick();
    end
    n_compared++;
    if (bad != 0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_no_output: got %0d valid cycles expected 0", bad);
    end
    send_sample(8'sd3, y, lat, ok);
    n_compared++;
    if (!ok || y !== 16'sd3) begin
      n_mismatched++;
      $display("[TB] FAIL reset_ring_cleared: got %0d (valid=%b) expected 3", y, ok);
    end
  endtask

  task automatic test_large();
`ifdef FIR_SAT_EN
    logic signed [15:0] yexp [4] = '{16'sd16129, 16'sd32258, 16'sd32767, 16'sd32767};
    logic signed [15:0] neg_exp = -16'sd32768;
`else
    logic signed [15:0] yexp [4] = '{16'sd16129, 16'sd32258, -16'sd17149, -16'sd1020};
    logic signed [15:0] neg_exp = 16'sd512;
`endif
    logic signed [15:0] y;
    int lat;
    bit ok;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set_coef(2'(i), 8'sd127);
    end
    for (int i = 0; i < 4; i++) begin
      send_sample(8'sd127, y, lat, ok);
      n_compared++;
      if (!ok || y !== yexp[i]) begin
        n_mismatched++;
        $display("[TB] FAIL large_pos[%0d]: got %0d (valid=%b) expected %0d", i, y, ok, yexp[i]);
      end
    end
    // 4 x (127 * -128) = -65024
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set_coef(2'(i), -8'sd128);
    end
    for (int i = 0; i < 4; i++) begin
      send_sample(8'sd127, y, lat, ok);
    end
    n_compared++;
    if (!ok || y !== neg_exp) begin
      n_mismatched++;
      $display("[TB] FAIL large_neg: got %0d (valid=%b) expected %0d", y, ok, neg_exp);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    test_reset();
    test_impulse_default();
    test_coef_impulse();
    test_step_wrap();
    test_backpressure();
    test_cfg_busy();
    test_cfg_with_sample();
    test_reset_mid_mac();
    test_large();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
